// File: rtl/ctrl_pkg.sv
// Shared constants for the pipelined control unit: opcode encodings,
// ALU operation codes, control-bundle widths and bit positions.
package ctrl_pkg;

  localparam int unsigned OPCODE_WIDTH = 5;
  localparam int unsigned ALUOP_WIDTH  = 2;

  // ex_ctrl is ALUOP_W bits of aluop plus this many single-bit flags
  localparam int unsigned EX_FLAG_N  = 6;
  localparam int unsigned MEM_CTRL_W = 4;
  localparam int unsigned WB_CTRL_W  = 2;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    ART  = 5'd0,
    LOG  = 5'd1,
    IMM  = 5'd2,
    CRY  = 5'd3,
    JMP  = 5'd4,
    BQE  = 5'd5,
    BNE  = 5'd6,
    CALL = 5'd7,
    RET  = 5'd8,
    LD   = 5'd9,
    ST   = 5'd10
  } opcode_e;

  typedef enum logic [ALUOP_WIDTH-1:0] {
    ALU_ADD   = 2'b00,
    ALU_LOGIC = 2'b01,
    ALU_CARRY = 2'b10
  } aluop_e;

  // ex_ctrl = {branch, branchtype, jump, ret, alusrc, regdist, aluop}
  // flag positions are offsets above the aluop field
  localparam int unsigned EXO_REGDIST = 0;
  localparam int unsigned EXO_ALUSRC  = 1;
  localparam int unsigned EXO_RET     = 2;
  localparam int unsigned EXO_JUMP    = 3;
  localparam int unsigned EXO_BRTYPE  = 4;
  localparam int unsigned EXO_BRANCH  = 5;

  // mem_ctrl = {memread, memwrite, push, pop}
  localparam int unsigned MEM_POP   = 0;
  localparam int unsigned MEM_PUSH  = 1;
  localparam int unsigned MEM_WRITE = 2;
  localparam int unsigned MEM_READ  = 3;

  // wb_ctrl = {regwrite, memtoreg}
  localparam int unsigned WB_MEMTOREG = 0;
  localparam int unsigned WB_REGWRITE = 1;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control-bundle table used in the ID stage.
// Unknown opcodes and invalid slots decode to an all-zero bubble.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = OPCODE_WIDTH,
  parameter int unsigned ALUOP_W  = ALUOP_WIDTH
) (
  input  logic [OPCODE_W-1:0]          opcode_i,
  input  logic                         valid_i,
  output logic [ALUOP_W+EX_FLAG_N-1:0] ex_ctrl_o,
  output logic [MEM_CTRL_W-1:0]        mem_ctrl_o,
  output logic [WB_CTRL_W-1:0]         wb_ctrl_o
);

  // decode table, all fields default to zero
  always_comb begin
    ex_ctrl_o  = '0;
    mem_ctrl_o = '0;
    wb_ctrl_o  = '0;
    if (valid_i) begin
      case (opcode_i)
        OPCODE_W'(ART): begin
          ex_ctrl_o[ALUOP_W+EXO_REGDIST] = 1'b1;
          ex_ctrl_o[ALUOP_W-1:0]         = ALUOP_W'(ALU_ADD);
          wb_ctrl_o[WB_REGWRITE]         = 1'b1;
        end
        OPCODE_W'(LOG): begin
          ex_ctrl_o[ALUOP_W+EXO_REGDIST] = 1'b1;
          ex_ctrl_o[ALUOP_W-1:0]         = ALUOP_W'(ALU_LOGIC);
          wb_ctrl_o[WB_REGWRITE]         = 1'b1;
        end
        OPCODE_W'(IMM): begin
          ex_ctrl_o[ALUOP_W+EXO_REGDIST] = 1'b1;
          ex_ctrl_o[ALUOP_W+EXO_ALUSRC]  = 1'b1;
          ex_ctrl_o[ALUOP_W-1:0]         = ALUOP_W'(ALU_ADD);
          wb_ctrl_o[WB_REGWRITE]         = 1'b1;
        end
        OPCODE_W'(CRY): begin
          ex_ctrl_o[ALUOP_W-1:0] = ALUOP_W'(ALU_CARRY);
          wb_ctrl_o[WB_REGWRITE] = 1'b1;
        end
        OPCODE_W'(JMP): begin
          ex_ctrl_o[ALUOP_W+EXO_JUMP] = 1'b1;
        end
        OPCODE_W'(BQE): begin
          ex_ctrl_o[ALUOP_W+EXO_BRANCH] = 1'b1;
        end
        OPCODE_W'(BNE): begin
          ex_ctrl_o[ALUOP_W+EXO_BRANCH] = 1'b1;
          ex_ctrl_o[ALUOP_W+EXO_BRTYPE] = 1'b1;
        end
        OPCODE_W'(CALL): begin
          ex_ctrl_o[ALUOP_W+EXO_JUMP] = 1'b1;
          mem_ctrl_o[MEM_PUSH]        = 1'b1;
        end
        OPCODE_W'(RET): begin
          ex_ctrl_o[ALUOP_W+EXO_RET] = 1'b1;
          mem_ctrl_o[MEM_POP]        = 1'b1;
        end
        OPCODE_W'(LD): begin
          mem_ctrl_o[MEM_READ]   = 1'b1;
          wb_ctrl_o[WB_REGWRITE] = 1'b1;
          wb_ctrl_o[WB_MEMTOREG] = 1'b1;
        end
        OPCODE_W'(ST): begin
          mem_ctrl_o[MEM_WRITE] = 1'b1;
        end
        default: begin
          ex_ctrl_o  = '0;
          mem_ctrl_o = '0;
          wb_ctrl_o  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/control_pipe.sv
// Pipelined control unit: decodes in ID and carries control bundles through
// EX/MEM/WB with valid bits, handling hazard bubbles, branch flush,
// memory-wait freeze and call-stack depth tracking.
// Optional macro CTRL_PERF_EN adds saturating stall/flush perf counters.
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = OPCODE_WIDTH,
  parameter int unsigned ALUOP_W     = ALUOP_WIDTH,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [OPCODE_W-1:0]          opcode,
  input  logic                         instr_valid,
  input  logic                         hazard,
  input  logic                         flush,
  input  logic                         mem_wait,
  output logic                         stall_id,
  output logic [ALUOP_W+EX_FLAG_N-1:0] ex_ctrl,
  output logic [MEM_CTRL_W-1:0]        mem_ctrl,
  output logic [WB_CTRL_W-1:0]         wb_ctrl,
  output logic [SP_W-1:0]              stack_ptr,
  output logic                         stack_ovf,
  output logic                         stack_unf
`ifdef CTRL_PERF_EN
  ,
  output logic [15:0]                  perf_stall_cnt,
  output logic [15:0]                  perf_flush_cnt
`endif
);

  localparam int unsigned EX_W = ALUOP_W + EX_FLAG_N;

  logic [EX_W-1:0]       dec_ex;
  logic [MEM_CTRL_W-1:0] dec_mem;
  logic [WB_CTRL_W-1:0]  dec_wb;

  ctrl_decode #(
    .OPCODE_W(OPCODE_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .opcode_i  (opcode),
    .valid_i   (instr_valid),
    .ex_ctrl_o (dec_ex),
    .mem_ctrl_o(dec_mem),
    .wb_ctrl_o (dec_wb)
  );

  // EX stage carries all three bundles, MEM carries mem+wb, WB carries wb
  logic                  ex_v_q,   ex_v_d;
  logic [EX_W-1:0]       ex_ex_q,  ex_ex_d;
  logic [MEM_CTRL_W-1:0] ex_mem_q, ex_mem_d;
  logic [WB_CTRL_W-1:0]  ex_wb_q,  ex_wb_d;
  logic                  mem_v_q,   mem_v_d;
  logic [MEM_CTRL_W-1:0] mem_mem_q, mem_mem_d;
  logic [WB_CTRL_W-1:0]  mem_wb_q,  mem_wb_d;
  logic                  wb_v_q,  wb_v_d;
  logic [WB_CTRL_W-1:0]  wb_wb_q, wb_wb_d;
  logic [SP_W-1:0]       sp_q,  sp_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  push_ok;
  logic                  pop_ok;
  logic                  freeze;
  logic                  mem_adv;
  logic [MEM_CTRL_W-1:0] mem_live;

  // MEM view with push/pop masked at the stack limits; masked ops never freeze
  always_comb begin
    push_ok  = (sp_q < SP_W'(STACK_DEPTH));
    pop_ok   = (sp_q != '0);
    mem_live = mem_v_q ? mem_mem_q : '0;
    if (!push_ok) mem_live[MEM_PUSH] = 1'b0;
    if (!pop_ok)  mem_live[MEM_POP]  = 1'b0;
    freeze   = mem_wait & (|mem_live);
    mem_adv  = mem_v_q & ~freeze;
    stall_id = freeze | (hazard & ~flush);
  end

  // stage advance with priority freeze > flush > hazard
  always_comb begin
    ex_v_d    = ex_v_q;
    ex_ex_d   = ex_ex_q;
    ex_mem_d  = ex_mem_q;
    ex_wb_d   = ex_wb_q;
    mem_v_d   = mem_v_q;
    mem_mem_d = mem_mem_q;
    mem_wb_d  = mem_wb_q;
    wb_v_d    = 1'b0;
    wb_wb_d   = '0;
    if (!freeze) begin
      wb_v_d    = mem_v_q;
      wb_wb_d   = mem_wb_q;
      mem_v_d   = ex_v_q;
      mem_mem_d = ex_mem_q;
      mem_wb_d  = ex_wb_q;
      if (flush || hazard) begin
        ex_v_d   = 1'b0;
        ex_ex_d  = '0;
        ex_mem_d = '0;
        ex_wb_d  = '0;
      end else begin
        ex_v_d   = instr_valid;
        ex_ex_d  = dec_ex;
        ex_mem_d = dec_mem;
        ex_wb_d  = dec_wb;
      end
    end
  end

  // call depth moves only as the MEM instruction retires from MEM
  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (mem_adv) begin
      if (mem_mem_q[MEM_PUSH]) begin
        if (push_ok) sp_d = sp_q + SP_W'(1);
        else         ovf_d = 1'b1;
      end else if (mem_mem_q[MEM_POP]) begin
        if (pop_ok) sp_d = sp_q - SP_W'(1);
        else        unf_d = 1'b1;
      end
    end
  end

  // pipeline and stack state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q    <= 1'b0;
      ex_ex_q   <= '0;
      ex_mem_q  <= '0;
      ex_wb_q   <= '0;
      mem_v_q   <= 1'b0;
      mem_mem_q <= '0;
      mem_wb_q  <= '0;
      wb_v_q    <= 1'b0;
      wb_wb_q   <= '0;
      sp_q      <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      ex_v_q    <= ex_v_d;
      ex_ex_q   <= ex_ex_d;
      ex_mem_q  <= ex_mem_d;
      ex_wb_q   <= ex_wb_d;
      mem_v_q   <= mem_v_d;
      mem_mem_q <= mem_mem_d;
      mem_wb_q  <= mem_wb_d;
      wb_v_q    <= wb_v_d;
      wb_wb_q   <= wb_wb_d;
      sp_q      <= sp_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign ex_ctrl   = ex_v_q ? ex_ex_q : '0;
  assign mem_ctrl  = mem_live;
  assign wb_ctrl   = wb_v_q ? wb_wb_q : '0;
  assign stack_ptr = sp_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

`ifdef CTRL_PERF_EN
  logic [15:0] pstall_q, pstall_d;
  logic [15:0] pflush_q, pflush_d;

  // saturating event counters
  always_comb begin
    pstall_d = pstall_q;
    pflush_d = pflush_q;
    if (stall_id && (pstall_q != '1))           pstall_d = pstall_q + 16'd1;
    if (flush && !freeze && (pflush_q != '1))   pflush_d = pflush_q + 16'd1;
  end

  // perf counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstall_q <= '0;
      pflush_q <= '0;
    end else begin
      pstall_q <= pstall_d;
      pflush_q <= pflush_d;
    end
  end

  assign perf_stall_cnt = pstall_q;
  assign perf_flush_cnt = pflush_q;
`endif

endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Pipelined control unit for the 19-bit CPU; successor to the single-cycle combinational decoder.
- Decodes the 5-bit opcode in ID into a control bundle and carries it through EX, MEM and WB stage registers with valid bits.
- Applies hazard bubbles, branch flush and memory-wait freeze.
- Tracks call-stack depth, masking push/pop on overflow/underflow.

Parameters:
- OPCODE_W, 5, opcode width; encodings are those of the shared opcode constants.
- ALUOP_W, 2, aluop field width.
- STACK_DEPTH, 8, maximum call depth; SP_W = $clog2(STACK_DEPTH+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  instruction opcode in ID.
- instr_valid  in  1  ID holds a real instruction; 0 decodes as bubble.
- hazard  in  1  load-use hazard: hold ID, inject bubble into EX.
- flush  in  1  branch/jump taken in EX: kill the ID instruction.
- mem_wait  in  1  data memory/stack not ready.
- stall_id  out  1  hold PC and IF/ID register.
- ex_ctrl  out  6+ALUOP_W  {branch, branchtype, jump, ret, alusrc, regdist, aluop}.
- mem_ctrl  out  4  {memread, memwrite, push, pop}.
- wb_ctrl  out  2  {regwrite, memtoreg}.
- stack_ptr  out  SP_W  current call depth.
- stack_ovf  out  1  sticky: a push was attempted at full depth.
- stack_unf  out  1  sticky: a pop was attempted at depth 0.

Behaviour:
- Decode table (combinational, ID):
  - ART: regdist, regwrite, aluop=00.
  - LOG: regdist, regwrite, aluop=01.
  - IMM: regdist, regwrite, alusrc, aluop=00.
  - CRY: regwrite, aluop=10.
  - JMP: jump.
  - BQE: branch, branchtype=0.
  - BNE: branch, branchtype=1.
  - CALL: push, jump.
  - RET: pop, ret.
  - LD: memread, memtoreg, regwrite.
  - ST: memwrite.
  - Any other opcode, or instr_valid=0: all zero.
- Latency: a valid opcode at edge n appears on ex_ctrl after edge n+1, mem_ctrl after n+2, wb_ctrl after n+3.
- Outputs are the registered stage fields ANDed with the stage valid bit; bubbles drive all zeros.
- freeze = mem_wait AND MEM valid AND (memread|memwrite|push|pop). mem_wait is ignored otherwise.
- Priority per edge, freeze > flush > hazard:
  - freeze: EX and MEM hold; WB loads a bubble; the ID instruction is not consumed.
  - flush (no freeze): EX loads a bubble; EX advances to MEM; hazard ignored that cycle.
  - hazard (no freeze/flush): EX loads a bubble; EX advances to MEM.
  - else: all stages advance.
- stall_id = freeze | (hazard & ~flush), combinational.
- Stack counter: updates only when MEM advances (MEM valid, not frozen).
  - push with stack_ptr<STACK_DEPTH: stack_ptr+1.
  - pop with stack_ptr>0: stack_ptr-1.
  - push at STACK_DEPTH: mem_ctrl.push masked to 0 combinationally, stack_ptr holds, stack_ovf set.
  - pop at 0: mem_ctrl.pop masked to 0, stack_ptr holds, stack_unf set.
  - Masked push/pop does not cause freeze.
  - Flags are cleared only by reset; no wrap-around.
- Reset (asynchronous, mid-operation included): all valid bits, bundles, stack_ptr and flags go to 0 immediately; stall_id=0 unless inputs assert it.

Optional Feature:
- Macro CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cnt and perf_flush_cnt, 16 bits each, saturating at 16'hFFFF, reset to 0.
  - perf_stall_cnt increments on every cycle stall_id=1.
  - perf_flush_cnt increments on every flush that is not frozen.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package ctrl_pkg:
  - Opcode constants (ART, LOG, JMP, BQE, BNE, CALL, RET, LD, ST, CRY, IMM).
  - ALUOP encodings.
  - Bit-index localparams for ex_ctrl/mem_ctrl/wb_ctrl.
  - Bundle widths.
- Sub-module ctrl_decode: purely combinational opcode-to-bundle table, instantiated once in ID.
- control_pipe: stage registers, priority logic and stack counter.

Test Plan:
- Reset, then LD valid at cycle 0: ex_ctrl all 0 at cycle 1; mem_ctrl=1000 at cycle 2; wb_ctrl=11 at cycle 3.
- Pipeline holds LD in MEM, ADD (ART) in EX, mem_wait=1 for 3 cycles: stall_id=1 for 3 cycles, WB shows 3 bubbles, then LD retires with wb_ctrl=11 and ART follows next cycle.
- BNE in ID with hazard=1 and flush=1 together: EX bubble, stall_id=0, BNE never reaches MEM.
- STACK_DEPTH=2, three CALLs: stack_ptr goes 1, 2; third CALL shows mem_ctrl.push=0, stack_ovf=1, stack_ptr=2.
- RET at stack_ptr=0: mem_ctrl.pop=0, stack_unf=1. Deassert rst_n mid-stream: all outputs and flags 0 immediately, without a clock edge.
- With CTRL_PERF_EN, hazard held 5 cycles then 2 flushes: perf_stall_cnt=5, perf_flush_cnt=2.
